// File: rtl/rsa_pkg.sv
// Shared widths, cycle counts and FSM state type for the RSA encryption datapath.
package rsa_pkg;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned KEY_W         = 8;
  localparam int unsigned REDUCE_CYCLES = 32;
  localparam int unsigned MODMUL_CYCLES = 33;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SQ,
    MUL,
    DONE
  } state_e;
endpackage

// File: rtl/mod_reduce_seq.sv
// Bit-serial restoring reducer: remainder of a 2W-bit operand modulo a W-bit modulus,
// one operand bit per cycle, MSB first, fixed 2W cycles from start to done.
module mod_reduce_seq
  import rsa_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [2*W-1:0] operand_i,
  input  logic [W-1:0]   modulus_i,
  output logic           done_o,
  output logic [W-1:0]   rem_o
);
  localparam int unsigned CW = $clog2(2 * W);
  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

  logic [2*W-1:0] shreg_q, shreg_d;
  logic [W-1:0]   rem_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;

  logic           bit_in;
  logic [W-1:0]   rem_base;
  logic [W:0]     shifted;
  logic [W:0]     rem_step;

  // The start cycle already consumes the operand MSB, so the last step lands on cnt == 2W-1.
  always_comb begin
    bit_in   = start_i ? operand_i[2*W-1] : shreg_q[2*W-1];
    rem_base = start_i ? '0 : rem_q;
    shreg_d  = start_i ? {operand_i[2*W-2:0], 1'b0} : {shreg_q[2*W-2:0], 1'b0};
    shifted  = {rem_base, bit_in};
    rem_step = (shifted >= {1'b0, modulus_i}) ? (shifted - {1'b0, modulus_i}) : shifted;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        shreg_q <= shreg_d;
        rem_q   <= rem_step[W-1:0];
        cnt_q   <= CW'(1);
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        shreg_q <= shreg_d;
        rem_q   <= rem_step[W-1:0];
        cnt_q   <= cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign rem_o  = rem_q;
endmodule

// File: rtl/rsa_encryptor.sv
// RSA encryption: ciphertext = message^public_key mod n by left-to-right square-and-multiply,
// every exponent bit scanned so latency depends only on popcount(public_key).
module rsa_encryptor
  import rsa_pkg::*;
#(
  parameter int unsigned DATA_W = rsa_pkg::DATA_W,
  parameter int unsigned KEY_W  = rsa_pkg::KEY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] message,
  input  logic [KEY_W-1:0]  public_key,
  input  logic [DATA_W-1:0] n,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] ciphertext,
  output logic              error
);
  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [KEY_W-1:0]  e_q, e_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              issue_q, issue_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] ct_q, ct_d;
  logic              error_q, error_d;

  logic [PW-1:0]     acc_w, m_w, red_operand;
  logic              red_start, red_done;
  logic [DATA_W-1:0] red_rem;

  always_comb begin
    acc_w       = PW'(acc_q);
    m_w         = PW'(m_q);
    red_operand = (state_q == MUL) ? (acc_w * m_w) : (acc_w * acc_w);
    red_start   = issue_q && ((state_q == SQ) || (state_q == MUL));
  end

  mod_reduce_seq #(.W(DATA_W)) u_reduce (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (red_start),
    .operand_i (red_operand),
    .modulus_i (n_q),
    .done_o    (red_done),
    .rem_o     (red_rem)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    n_d     = n_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    issue_d = issue_q;
    err_d   = err_q;
    done_d  = 1'b0;
    ct_d    = ct_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          m_d     = message;
          e_d     = public_key;
          n_d     = n;
          acc_d   = DATA_W'(1);
          idx_d   = IW'(KEY_W - 1);
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((n_q < DATA_W'(2)) || (m_q >= n_q)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          issue_d = 1'b1;
          state_d = SQ;
        end
      end
      SQ, MUL: begin
        if (issue_q) begin
          issue_d = 1'b0;
        end else if (red_done) begin
          acc_d = red_rem;
          if ((state_q == SQ) && e_q[idx_q]) begin
            issue_d = 1'b1;
            state_d = MUL;
          end else if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IW'(1);
            issue_d = 1'b1;
            state_d = SQ;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        ct_d    = err_q ? '0 : acc_q;
        error_d = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      issue_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ct_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      issue_q <= issue_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ct_q    <= ct_d;
      error_q <= error_d;
    end
  end

  // done is registered out of DONE, so ready stays low through the pulse cycle.
  assign ready      = (state_q == IDLE) && !done_q;
  assign done       = done_q;
  assign ciphertext = ct_q;
  assign error      = error_q;
endmodule

// File: tb/tb_rsa_encryptor.sv
// Directed bench for rsa_encryptor: hand-computed ciphertexts, latencies and control corner cases.
module tb_rsa_encryptor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] message = '0;
  logic [7:0]  public_key = '0;
  logic [15:0] n = '0;
  logic        ready, done, error;
  logic [15:0] ciphertext;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  rsa_encryptor #(.DATA_W(16), .KEY_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .message    (message),
    .public_key (public_key),
    .n          (n),
    .ready      (ready),
    .done       (done),
    .ciphertext (ciphertext),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] m);
    logic [63:0] r, x;
    logic [31:0] k;
    r = 64'd1;
    x = 64'(b % m);
    k = e;
    while (k != 0) begin
      if (k[0]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
      k = k >> 1;
    end
    return r[31:0];
  endfunction

  // Starts one request and follows it to done; noisy mode pokes start and the
  // inputs while busy, which must not disturb the accepted request.
  task automatic run(input string tag, input logic [15:0] m, input logic [7:0] e,
                     input logic [15:0] nn, input logic [15:0] exp_ct, input logic exp_err,
                     input int unsigned exp_lat, input bit noisy, output logic [15:0] ct);
    int unsigned edges;
    int unsigned lat;
    int unsigned extra;
    bit seen;
    @(negedge clk);
    check_eq({tag, "_ready_pre"}, 32'(ready), 32'd1);
    start = 1'b1; message = m; public_key = e; n = nn;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (noisy) message = ~m;
    edges = 0; seen = 0; lat = 9999;
    while (edges < 2000 && !seen) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) check_eq({tag, "_ready_busy"}, 32'(ready), 32'd0);
      if (done) begin
        seen = 1;
        lat  = edges;
        check_eq({tag, "_ready_at_done"}, 32'(ready), 32'd0);
      end
      if (noisy && (edges == 5 || edges == 50)) begin
        start = 1'b1; message = 16'd2; public_key = 8'hFF; n = 16'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_ct"}, 32'(ciphertext), 32'(exp_ct));
    check_eq({tag, "_err"}, 32'(error), 32'(exp_err));
    ct = ciphertext;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_ready_post"}, 32'(ready), 32'd1);
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    if (noisy) begin
      extra = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (done) extra++;
      end
      check_eq({tag, "_no_second_done"}, extra, 32'd0);
      check_eq({tag, "_ct_held"}, 32'(ciphertext), 32'(exp_ct));
    end
  endtask

  initial begin
    logic [15:0] ct;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ct", 32'(ciphertext), 32'd0);
    check_eq("rst_err", 32'(error), 32'd0);

    run("rsa3233", 16'd65, 8'd17, 16'd3233, 16'd2790, 1'b0, 332, 0, ct);
    check_eq("decrypt_roundtrip", modexp(32'(ct), 32'd2753, 32'd3233), 32'd65);
    run("n15_e3", 16'd7, 8'd3, 16'd15, 16'd13, 1'b0, 332, 0, ct);
    run("n15_e0", 16'd5, 8'd0, 16'd15, 16'd1, 1'b0, 266, 0, ct);
    run("err_m_eq_n", 16'd3233, 8'd17, 16'd3233, 16'd0, 1'b1, 2, 0, ct);
    run("err_n1", 16'd0, 8'd17, 16'd1, 16'd0, 1'b1, 2, 0, ct);
    run("noisy", 16'd65, 8'd17, 16'd3233, 16'd2790, 1'b0, 332, 1, ct);

    // Abort a run mid-flight with reset.
    @(negedge clk);
    start = 1'b1; message = 16'd65; public_key = 8'd17; n = 16'd3233;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_ct", 32'(ciphertext), 32'd0);
    check_eq("abort_err", 32'(error), 32'd0);
    rst = 1'b0;
    run("after_abort", 16'd65, 8'd17, 16'd3233, 16'd2790, 1'b0, 332, 0, ct);

    // Reset and start together: start is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; message = 16'd7; public_key = 8'd3; n = 16'd15;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_eq("rst_start_ready", 32'(ready), 32'd1);
    begin
      int unsigned dcount;
      int unsigned busy;
      dcount = 0; busy = 0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (done) dcount++;
        if (!ready) busy++;
      end
      check_eq("rst_start_no_done", dcount, 32'd0);
      check_eq("rst_start_stays_idle", busy, 32'd0);
    end

    run("m_minus1", 16'd65520, 8'd255, 16'd65521, 16'd65520, 1'b0, 530, 0, ct);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
